// File: rtl/iterative_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iterative_divider_pkg
//  Description : Shared FSM encoding and constants for the iterative divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package iterative_divider_pkg;

  // Controller states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIXUP  = 2'd2,
    DONE   = 2'd3
  } div_state_t;

  // Widest operand supported; constants are sized to it and sliced by users
  localparam int MAX_WIDTH = 64;

  // Quotient reported for a zero divisor (all ones at any width)
  localparam logic [MAX_WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage
`default_nettype wire

// File: rtl/iterative_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : iterative_divider_if
//  Description : Operand/result handshake bundle for the iterative divider.
//  Revision    : 1.0 - initial release
// ============================================================================
interface iterative_divider_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // Requester side: supplies operands, consumes results
  modport master (
    output in_valid, is_signed, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  // Divider side
  modport slave (
    input  in_valid, is_signed, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/iterative_divider_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One restoring shift-subtract iteration (combinational).
//                Shifts the next dividend bit into the partial remainder and
//                subtracts the divisor when it fits, emitting one quotient bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             take;

  // The partial remainder stays below the divisor, so the shifted value fits
  // in WIDTH+1 bits; the extra top bit only serves as the borrow indicator.
  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign diff    = shifted - {2'b00, divisor};
  assign take    = ~diff[WIDTH+1];
  assign rem_out = take ? diff[WIDTH:0] : shifted[WIDTH:0];
  assign quo_out = {quo_in[WIDTH-2:0], take};

endmodule
`default_nettype wire

// File: rtl/iterative_divider.sv
`default_nettype none
// ============================================================================
//  Module      : iterative_divider
//  Description : Radix-2 restoring divider, signed/unsigned, one quotient bit
//                per cycle, valid/ready handshake on operands and results.
//  Revision    : 1.0 - initial release
// ============================================================================
module iterative_divider #(
  parameter int WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 flush,
  iterative_divider_if.slave  bus
);
  import iterative_divider_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       state;
  div_state_t       state_next;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   part_rem;
  logic [WIDTH-1:0] quo_shift;
  logic [WIDTH-1:0] div_mag;
  logic             neg_quo;
  logic             neg_rem;
  logic [WIDTH-1:0] res_quotient;
  logic [WIDTH-1:0] res_remainder;
  logic             res_dbz;

  logic             accept;
  logic             divisor_zero;
  logic             dividend_neg;
  logic             divisor_neg;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;

  assign accept       = bus.in_valid && (state == IDLE);
  assign divisor_zero = (bus.divisor == '0);
  assign dividend_neg = bus.is_signed && bus.dividend[WIDTH-1];
  assign divisor_neg  = bus.is_signed && bus.divisor[WIDTH-1];
  assign dividend_mag = dividend_neg ? (~bus.dividend + 1'b1) : bus.dividend;
  assign divisor_mag  = divisor_neg  ? (~bus.divisor  + 1'b1) : bus.divisor;

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.quotient    = res_quotient;
  assign bus.remainder   = res_remainder;
  assign bus.div_by_zero = res_dbz;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (part_rem),
    .quo_in  (quo_shift),
    .divisor (div_mag),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; flush wins over every other input
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = divisor_zero ? DONE : DIVIDE;
      DIVIDE:  if (count == CW'(1)) state_next = FIXUP;
      FIXUP:   state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Datapath: operand capture, iteration, sign fixup and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count         <= '0;
      part_rem      <= '0;
      quo_shift     <= '0;
      div_mag       <= '0;
      neg_quo       <= 1'b0;
      neg_rem       <= 1'b0;
      res_quotient  <= '0;
      res_remainder <= '0;
      res_dbz       <= 1'b0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (divisor_zero) begin
              res_quotient  <= DBZ_QUOTIENT[WIDTH-1:0];
              res_remainder <= bus.dividend;
              res_dbz       <= 1'b1;
            end else begin
              part_rem  <= '0;
              quo_shift <= dividend_mag;
              div_mag   <= divisor_mag;
              count     <= CW'(WIDTH);
              neg_quo   <= dividend_neg ^ divisor_neg;
              neg_rem   <= dividend_neg;
              res_dbz   <= 1'b0;
            end
          end
        end
        DIVIDE: begin
          part_rem  <= step_rem;
          quo_shift <= step_quo;
          count     <= count - 1'b1;
        end
        FIXUP: begin
          res_quotient  <= neg_quo ? (~quo_shift + 1'b1) : quo_shift;
          res_remainder <= neg_rem ? (~part_rem[WIDTH-1:0] + 1'b1)
                                   : part_rem[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/iterative_divider.md
ITERATIVE_DIVIDER -- requirements
Module: iterative_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal range 4..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port flush  input  1  synchronous abort of any operation in flight.
REQ-005 SHALL have port in_valid  input  1  operands presented.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port is_signed  input  1  1 = two's-complement divide, 0 = unsigned.
REQ-008 SHALL have port dividend  input  WIDTH  numerator.
REQ-009 SHALL have port divisor  input  WIDTH  denominator.
REQ-010 SHALL have port out_valid  output  1  results valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts results.
REQ-012 SHALL have ports quotient and remainder  output  WIDTH each  results.
REQ-013 SHALL have port div_by_zero  output  1  divisor was zero for the current result.

Function
REQ-014 SHALL implement FSM states IDLE, DIVIDE, FIXUP, DONE; in_ready = (state == IDLE) only.
REQ-015 SHALL accept operands on a rising edge with in_valid && in_ready, registering dividend, divisor, is_signed.
REQ-016 SHALL, on acceptance with divisor != 0, convert signed operands to magnitudes, clear the partial remainder, load bit counter WIDTH, and enter DIVIDE.
REQ-017 SHALL, in DIVIDE, retire exactly one quotient bit per cycle by restoring shift-subtract, MSB first, for WIDTH cycles, then enter FIXUP.
REQ-018 SHALL, in FIXUP, negate quotient if operand signs differ and negate remainder if dividend was negative (signed mode only), then enter DONE.
REQ-019 SHALL assert out_valid exactly WIDTH+1 rising edges after the accepting edge for nonzero divisors.
REQ-020 SHALL, on acceptance with divisor == 0, enter DONE directly (out_valid after 1 edge) with quotient all-ones, remainder = dividend, div_by_zero = 1.
REQ-021 SHALL, in signed mode, produce quotient = most-negative value, remainder = 0, div_by_zero = 0 for most-negative / -1, with normal latency.
REQ-022 SHALL hold quotient, remainder, div_by_zero stable while out_valid && !out_ready.
REQ-023 SHALL return to IDLE on the edge where out_valid && out_ready; in_ready rises the following cycle (no same-cycle back-to-back).
REQ-024 SHALL, on flush high at an edge, go to IDLE from any state, drop out_valid, discard results; flush overrides in_valid and out_ready that edge.
REQ-025 SHALL keep remainder magnitude < divisor magnitude and remainder sign = dividend sign (truncating division) for all nonzero divisors.
REQ-026 SHALL use a WIDTH+1-bit partial remainder to avoid overflow; no other internal width beyond 2*WIDTH+1 bits of shift state.
REQ-027 SHALL ignore in_valid outside IDLE; operand inputs need not be held after acceptance.

Reset
REQ-028 SHALL, on rst_n low, immediately force state IDLE, out_valid 0, in_ready 1 after release, quotient 0, remainder 0, div_by_zero 0, counter 0.
REQ-029 SHALL abandon any operation on reset mid-DIVIDE with no result produced after release.

Structure
REQ-030 SHALL place the FSM state encoding and the divide-by-zero quotient constant (all-ones) in a shared divider package.
REQ-031 SHALL factor one shift-subtract iteration into sub-module div_step (combinational, WIDTH-parametrised), instantiated once.
REQ-032 SHALL be fully synchronous apart from rst_n, with no latches and no combinational path in_valid -> out_valid.

Verification (WIDTH = 32)
REQ-033 SHALL test unsigned 100 / 7 -> quotient 14, remainder 2, div_by_zero 0, out_valid 33 edges after accept.
REQ-034 SHALL test signed -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7 / -2 -> 0xFFFFFFFD, 1.
REQ-035 SHALL test 5 / 0 (both modes) -> quotient 0xFFFFFFFF, remainder 5, div_by_zero 1, out_valid 1 edge after accept.
REQ-036 SHALL test signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned same operands -> quotient 0, remainder 0x80000000.
REQ-037 SHALL test out_ready held low 10 cycles after out_valid -> outputs unchanged, in_ready 0, then one-cycle handshake -> IDLE.
REQ-038 SHALL test rst_n low and flush high at DIVIDE cycle 10 -> out_valid never asserts for that operation; a following 0xFFFFFFFF / 16 yields 0x0FFFFFFF, 15.
